// File: rtl/cascade_host_pkg.sv
// Shared types and frame-size helpers for the cascade stream host.
// Optional checksum feature is enabled by defining CASCADE_STREAM_HOST_CHECKSUM_EN.
package cascade_host_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Two chained valid 3x3 stages each trim one pixel from every border.
    function automatic int calc_n_in(input int img_w, input int img_h);
        return img_w * img_h;
    endfunction

    function automatic int calc_n_out(input int img_w, input int img_h);
        return (img_w - 4) * (img_h - 4);
    endfunction

endpackage

// File: rtl/cascade_host_fifo.sv
// First-word fall-through FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle. Pointers carry one extra wrap bit.
module cascade_host_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/cascade_stream_host.sv
// Host-side responder for an accelerator's read-enable / write-valid stream pair.
// Define CASCADE_STREAM_HOST_CHECKSUM_EN to build the output checksum adder.
module cascade_stream_host
    import cascade_host_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             acc_read_en,
    output logic [WIDTH-1:0] acc_read_data,
    input  logic             acc_write_valid,
    input  logic [WIDTH-1:0] acc_write_data,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             done,
    output logic             underflow,
    output logic             overflow,
    output logic [WIDTH-1:0] checksum,
    output logic [1:0]       state_dbg
);

    localparam int N_IN  = calc_n_in(IMG_W, IMG_H);
    localparam int N_OUT = calc_n_out(IMG_W, IMG_H);
    localparam int CNT_W = $clog2(N_IN + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             underflow_q, underflow_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] held_q, held_d;

    logic             run;
    logic             start_ok;
    logic             in_push, in_pop, in_empty, in_full;
    logic             out_push, out_pop, out_empty, out_full;
    logic             wr_attempt;
    logic [WIDTH-1:0] in_head;

    assign run        = (state_q == RUN);
    assign start_ok   = (state_q == IDLE) && start;
    assign wr_attempt = run && acc_write_valid;

    // Valid/ready: a transfer happens in exactly the cycle where both are high;
    // ready may depend on a same-cycle pop so a full FIFO can stream through.
    assign in_pop   = run && acc_read_en && !in_empty;
    assign s_ready  = run && (in_cnt_q < CNT_W'(N_IN)) && (!in_full || in_pop);
    assign in_push  = s_valid && s_ready;
    assign m_valid  = !out_empty;
    assign out_pop  = m_valid && m_ready;
    assign out_push = wr_attempt && (!out_full || out_pop);

    assign acc_read_data = in_empty ? held_q : in_head;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign underflow     = underflow_q;
    assign overflow      = overflow_q;
    assign state_dbg     = state_q;

    cascade_host_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (start_ok),
        .push_i  (in_push),
        .wdata_i (s_data),
        .pop_i   (in_pop),
        .rdata_o (in_head),
        .empty_o (in_empty),
        .full_o  (in_full)
    );

    cascade_host_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (start_ok),
        .push_i  (out_push),
        .wdata_i (acc_write_data),
        .pop_i   (out_pop),
        .rdata_o (m_data),
        .empty_o (out_empty),
        .full_o  (out_full)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (out_cnt_q == CNT_W'(N_OUT)) state_d = DRAIN;
            DRAIN:   if (out_empty) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        held_d      = in_empty ? held_q : in_head;
        if (start_ok) begin
            in_cnt_d    = '0;
            out_cnt_d   = '0;
            underflow_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            if (in_push)                           in_cnt_d    = in_cnt_q + 1'b1;
            if (wr_attempt)                        out_cnt_d   = out_cnt_q + 1'b1;
            if (run && acc_read_en && in_empty)    underflow_d = 1'b1;
            if (wr_attempt && !out_push)           overflow_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            held_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            held_q      <= held_d;
        end
    end

`ifdef CASCADE_STREAM_HOST_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (start_ok)      checksum_d = '0;
        else if (out_push) checksum_d = checksum_q + acc_write_data;
    end

    always_ff @(posedge clk) begin
        if (reset) checksum_q <= '0;
        else       checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule
